// File: rtl/rx_edge_bit_counter_p_pkg.sv
// Shared types, legal prescale values and frame-length helper
// for the RX edge/bit counter.
package rx_edge_bit_counter_p_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_e;

  localparam int PRESC_8  = 8;
  localparam int PRESC_16 = 16;
  localparam int PRESC_32 = 32;

  function automatic int frame_len(
    input int   data_w,
    input logic par_en,
    input logic stop2
  );
    return 2 + data_w + int'(par_en) + int'(stop2);
  endfunction

endpackage

// File: rtl/rx_edge_bit_counter_p_presc_cfg_chk.sv
// Prescale legality decode and per-bit sample/last-edge positions.
// Legality uses the live input; positions use the latched ratio.
module rx_presc_cfg_chk
  import rx_edge_bit_counter_p_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic [PRESCALE_W-1:0] presc_raw_i,
  input  logic [PRESCALE_W-1:0] presc_lat_i,
  output logic                  legal_o,
  output logic [PRESCALE_W-1:0] last_o,
  output logic [PRESCALE_W-1:0] smp0_o,
  output logic [PRESCALE_W-1:0] smp1_o,
  output logic [PRESCALE_W-1:0] smp2_o
);

  logic [PRESCALE_W-1:0] half;

  assign legal_o = (presc_raw_i == PRESCALE_W'(PRESC_8))
                || (presc_raw_i == PRESCALE_W'(PRESC_16))
                || (presc_raw_i == PRESCALE_W'(PRESC_32));

  assign half   = presc_lat_i >> 1;
  assign last_o = presc_lat_i - PRESCALE_W'(1);
  assign smp0_o = half - PRESCALE_W'(1);
  assign smp1_o = half;
  assign smp2_o = half + PRESCALE_W'(1);

endmodule

// File: rtl/rx_edge_bit_counter_p.sv
// UART RX frame timing: oversample edge counter, bit counter,
// mid-bit sample strobes and frame completion pulses.
module rx_edge_bit_counter_p
  import rx_edge_bit_counter_p_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PRESCALE_W = 6,
  parameter int BIT_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  input  logic                  par_en_i,
  input  logic                  stop2_i,
  output logic [PRESCALE_W-1:0] edge_count_o,
  output logic [BIT_W-1:0]      bit_count_o,
  output logic                  sample_stb_o,
  output logic [1:0]            sample_idx_o,
  output logic                  bit_done_o,
  output logic                  frame_done_o,
  output logic                  busy_o,
  output logic                  cfg_err_o
);

  state_e                state_q, state_d;
  logic [PRESCALE_W-1:0] edge_q, edge_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic                  par_q, par_d;
  logic                  stop2_q, stop2_d;

  logic                  legal;
  logic [PRESCALE_W-1:0] last, smp0, smp1, smp2;
  logic [BIT_W-1:0]      fl_m1;
  logic                  last_edge, last_bit, run;

  rx_presc_cfg_chk #(
    .PRESCALE_W(PRESCALE_W)
  ) u_chk (
    .presc_raw_i(prescale_i),
    .presc_lat_i(presc_q),
    .legal_o    (legal),
    .last_o     (last),
    .smp0_o     (smp0),
    .smp1_o     (smp1),
    .smp2_o     (smp2)
  );

  assign fl_m1     = BIT_W'(frame_len(DATA_W, par_q, stop2_q) - 1);
  assign last_edge = (edge_q == last);
  assign last_bit  = (bit_q == fl_m1);
  assign run       = (state_q == ST_COUNT) && enable_i;

  always_comb begin
    state_d = state_q;
    edge_d  = edge_q;
    bit_d   = bit_q;
    presc_d = presc_q;
    par_d   = par_q;
    stop2_d = stop2_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enable_i && legal) begin
          state_d = ST_COUNT;
          presc_d = prescale_i;
          par_d   = par_en_i;
          stop2_d = stop2_i;
        end
      end
      ST_COUNT: begin
        if (!enable_i) begin
          state_d = ST_IDLE;
          edge_d  = '0;
          bit_d   = '0;
        end else if (last_edge) begin
          edge_d = '0;
          if (last_bit) begin
            state_d = ST_IDLE;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          edge_d = edge_q + PRESCALE_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      edge_q  <= '0;
      bit_q   <= '0;
      presc_q <= PRESCALE_W'(PRESC_8);
      par_q   <= 1'b0;
      stop2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      edge_q  <= edge_d;
      bit_q   <= bit_d;
      presc_q <= presc_d;
      par_q   <= par_d;
      stop2_q <= stop2_d;
    end
  end

  // Strobes are gated by enable so an abort cycle emits nothing.
  assign edge_count_o = edge_q;
  assign bit_count_o  = bit_q;
  assign busy_o       = (state_q == ST_COUNT);
  assign bit_done_o   = run && last_edge;
  assign frame_done_o = run && last_edge && last_bit;
  assign sample_stb_o = run && ((edge_q == smp0)
                             || (edge_q == smp1)
                             || (edge_q == smp2));
  assign sample_idx_o = !run            ? 2'd0 :
                        (edge_q == smp1) ? 2'd1 :
                        (edge_q == smp2) ? 2'd2 : 2'd0;
  assign cfg_err_o    = !rst && (state_q == ST_IDLE)
                     && enable_i && !legal;

endmodule

// File: tb/tb_rx_edge_bit_counter_p.sv
// Directed self-checking bench for rx_edge_bit_counter_p.
// Expected timing is derived from P, FL and cycle index.
module tb_rx_edge_bit_counter_p;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [5:0] prescale;
  logic       par_en;
  logic       stop2;
  logic [5:0] edge_count;
  logic [3:0] bit_count;
  logic       sample_stb;
  logic [1:0] sample_idx;
  logic       bit_done;
  logic       frame_done;
  logic       busy;
  logic       cfg_err;

  int total = 0;
  int bad   = 0;

  rx_edge_bit_counter_p dut (
    .clk         (clk),
    .rst         (rst),
    .enable_i    (enable),
    .prescale_i  (prescale),
    .par_en_i    (par_en),
    .stop2_i     (stop2),
    .edge_count_o(edge_count),
    .bit_count_o (bit_count),
    .sample_stb_o(sample_stb),
    .sample_idx_o(sample_idx),
    .bit_done_o  (bit_done),
    .frame_done_o(frame_done),
    .busy_o      (busy),
    .cfg_err_o   (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a frame from IDLE and follows it cycle by cycle.
  task automatic run_frame(input int p, input bit par, input bit s2,
                           input int fl, input string tag,
                           input bit keep);
    int n, e, b, errs, bd, fd, half;
    bit exp_stb;
    logic [1:0] exp_idx;
    prescale = 6'(p);
    par_en   = par;
    stop2    = s2;
    enable   = 1'b1;
    half     = p / 2;
    n = 0; errs = 0; bd = 0; fd = 0;
    while (fd == 0 && n < p * fl + 8) begin
      tick();
      n++;
      e = (n - 1) % p;
      b = (n - 1) / p;
      exp_stb = (e == half - 1) || (e == half) || (e == half + 1);
      exp_idx = (e == half) ? 2'd1 : (e == half + 1) ? 2'd2 : 2'd0;
      if (int'(edge_count) != e) errs++;
      if (int'(bit_count) != b) errs++;
      if (busy !== 1'b1) errs++;
      if (bit_done !== (e == p - 1)) errs++;
      if (frame_done !== (e == p - 1 && b == fl - 1)) errs++;
      if (sample_stb !== exp_stb) errs++;
      if (sample_idx !== exp_idx) errs++;
      if (bit_done) bd++;
      if (frame_done) fd = n;
      if (n == p * 3) begin
        prescale = (p == 8) ? 6'd16 : 6'd8;
        par_en   = ~par;
        stop2    = ~s2;
      end
    end
    chk({tag, "_seq"}, errs, 0);
    chk({tag, "_fdcyc"}, fd, p * fl);
    chk({tag, "_bdcnt"}, bd, fl);
    if (!keep) enable = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b1;
    prescale = 6'd12;
    par_en = 1'b0;
    stop2 = 1'b0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_edge", edge_count, 0);
    chk("rst_bit", bit_count, 0);
    chk("rst_cfgerr", cfg_err, 0);
    chk("rst_strb", {bit_done, frame_done, sample_stb}, 0);
    enable = 1'b0;
    prescale = 6'd8;
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    // P=8, 1 stop, no parity: FL=10
    run_frame(8, 1'b0, 1'b0, 10, "p8", 1'b0);
    tick();
    chk("p8_idle", busy, 0);

    // P=16, parity, 2 stop: FL=12
    run_frame(16, 1'b1, 1'b1, 12, "p16", 1'b0);
    tick();
    chk("p16_idle", busy, 0);

    // illegal prescale refused
    prescale = 6'd12;
    enable = 1'b1;
    #1;
    chk("cfg_err0", cfg_err, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("cfg_err_n", cfg_err, 1);
      chk("cfg_busy", busy, 0);
    end
    prescale = 6'd32;
    #1;
    chk("cfg_legal", cfg_err, 0);
    tick();
    chk("p32_busy", busy, 1);
    chk("p32_edge", edge_count, 0);
    enable = 1'b0;
    #1;
    chk("abort_nostb", {bit_done, frame_done, sample_stb}, 0);
    tick();
    chk("p32_abort", busy, 0);

    // abort at bit 4 edge 5 with P=16
    prescale = 6'd16;
    par_en = 1'b0;
    stop2 = 1'b0;
    enable = 1'b1;
    repeat (70) tick();
    chk("ab_bit", bit_count, 4);
    chk("ab_edge", edge_count, 5);
    enable = 1'b0;
    #1;
    chk("ab_fd", frame_done, 0);
    tick();
    chk("ab_busy", busy, 0);
    chk("ab_cnt", {edge_count, bit_count}, 0);

    // reset mid-frame at bit 6
    prescale = 6'd8;
    enable = 1'b1;
    repeat (50) tick();
    chk("rs_bit", bit_count, 6);
    #2;
    rst = 1'b1;
    #1;
    chk("rs_busy", busy, 0);
    chk("rs_cnt", {edge_count, bit_count}, 0);
    chk("rs_pulse", {frame_done, cfg_err, bit_done}, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("rs_restart", busy, 1);
    chk("rs_cnt0", {edge_count, bit_count}, 0);
    enable = 1'b0;
    tick();

    // back-to-back frames, P=8
    run_frame(8, 1'b0, 1'b0, 10, "bb", 1'b1);
    prescale = 6'd8;
    tick();
    chk("bb_gap", busy, 0);
    tick();
    chk("bb_busy2", busy, 1);
    chk("bb_edge2", edge_count, 0);
    tick();
    chk("bb_edge3", edge_count, 1);
    enable = 1'b0;
    tick();
    chk("bb_end", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
